// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command to APB setup/access bridge with a registered response port.
// Define APB_CMD_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_cmd_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH/8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSELx,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [STRB_WIDTH-1:0] PSTRB,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERR
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
   state_e                state_q;
   logic                  cmd_ready_q, psel_q, penable_q, pwrite_q;
   logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [DATA_WIDTH-1:0] pwdata_q, rsp_rdata_q;
   logic [STRB_WIDTH-1:0] pstrb_q;
   logic                  accept, timeout;
   assign accept = state_q == IDLE && cmd_valid && cmd_ready_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign cnt_d   = cnt_q + 1'b1;
   assign timeout = !PREADY && cnt_d == CW'(TIMEOUT_CYCLES);
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) cnt_q <= '0;
      else if (accept) cnt_q <= '0;
      else if (state_q == ACCESS && !PREADY) cnt_q <= cnt_d;
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cmd_ready_q <= !accept;
               if (accept) begin
                  psel_q   <= 1'b1;
                  paddr_q  <= cmd_addr;
                  pwrite_q <= cmd_write;
                  pwdata_q <= cmd_wdata;
                  pstrb_q  <= cmd_write ? cmd_strb : '0;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS:
               if (PREADY || timeout) begin
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= PREADY && !pwrite_q ? PRDATA : '0;
                  rsp_err_q     <= PREADY ? PSLVERR : 1'b1;
                  rsp_timeout_q <= !PREADY;
                  state_q       <= RESP;
               end
            default:
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
         endcase
      end
   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign PADDR       = paddr_q;
   assign PSELx       = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign PSTRB       = pstrb_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table-driven APB transfers with a response scoreboard plus reset/timeout sequences.
module tb_apb_cmd_master;
   logic        PCLK = 1'b0, PRESETn = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0, PRDATA = '0;
   logic [3:0]  cmd_strb = '0;
   logic        PREADY = 1'b0, PSLVERR = 1'b0;
   logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, PWRITE;
   logic [31:0] rsp_rdata, PADDR, PWDATA;
   logic [3:0]  PSTRB;

   always #5 PCLK = ~PCLK;

   apb_cmd_master dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          bp;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } rsp_t;

   rsp_t sb[$];
   vec_t tbl[6];
   int   n_chk = 0, n_fail = 0;

   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_ready;
      int k = 0;
      while (!cmd_ready && k < 20) begin
         tick;
         k++;
      end
      chk("cmd_ready_wait", cmd_ready, 1);
   endtask

   task automatic take_rsp(input string nm);
      rsp_t r;
      int   k = 0;
      while (!rsp_valid && k < 200) begin
         tick;
         k++;
      end
      chk({nm, "_rsp_valid"}, rsp_valid, 1);
      rsp_ready = 1'b1;
      if (sb.size() == 0) chk({nm, "_sb_empty"}, 1, 0);
      else begin
         r = sb.pop_front();
         chk({nm, "_rdata"}, rsp_rdata, r.rdata);
         chk({nm, "_err"}, rsp_err, r.err);
         chk({nm, "_tmo"}, rsp_timeout, r.tmo);
      end
      tick;
      rsp_ready = 1'b0;
      chk({nm, "_rsp_drop"}, rsp_valid, 0);
      chk({nm, "_ready_back"}, cmd_ready, 1);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      wait_ready;
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      sb.push_back('{v.exp_rdata, v.exp_err, 1'b0});
      tick;
      // keep a conflicting command on the port; it must be ignored until IDLE
      cmd_addr  = ~v.addr;
      cmd_write = ~v.wr;
      chk({nm, "_setup_sel"}, {PSELx, PENABLE, cmd_ready}, 3'b100);
      chk({nm, "_setup_addr"}, PADDR, v.addr);
      chk({nm, "_setup_dir"}, PWRITE, v.wr);
      chk({nm, "_setup_wdata"}, PWDATA, v.wdata);
      chk({nm, "_setup_strb"}, PSTRB, v.wr ? v.strb : 4'h0);
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      tick;
      for (int i = 0; i < v.waits; i++) begin
         PREADY  = 1'b0;
         PSLVERR = 1'b1;
         PRDATA  = 32'hBAD0_0000 | i;
         chk({nm, "_wait_bus"}, {PSELx, PENABLE, rsp_valid, cmd_ready}, 4'b1100);
         chk({nm, "_wait_addr"}, PADDR, v.addr);
         tick;
      end
      chk({nm, "_access"}, {PSELx, PENABLE, rsp_valid}, 3'b110);
      chk({nm, "_access_wdata"}, PWDATA, v.wdata);
      PREADY    = 1'b1;
      PRDATA    = v.prdata;
      PSLVERR   = v.slverr;
      cmd_valid = 1'b0;
      rsp_ready = v.bp == 0;
      tick;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      chk({nm, "_resp_bus"}, {PSELx, PENABLE, rsp_valid}, 3'b001);
      for (int i = 0; i < v.bp; i++) begin
         chk({nm, "_bp_hold"}, {rsp_valid, rsp_err, cmd_ready}, {1'b1, v.exp_err, 1'b0});
         chk({nm, "_bp_rdata"}, rsp_rdata, v.exp_rdata);
         tick;
      end
      take_rsp(nm);
      chk({nm, "_idle_hold"}, PADDR, v.addr);
   endtask

   initial begin
      tbl[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0, 0, 32'h0,         1'b0};
      tbl[1] = '{1'b0, 32'h0000_0008, 32'h1111_2222, 4'hF, 3, 32'h1234_5678, 1'b0, 1, 32'h1234_5678, 1'b0};
      tbl[2] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h3, 0, 32'h0,         1'b1, 5, 32'h0,         1'b1};
      tbl[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 0, 32'hA5A5_5A5A, 1'b1, 0, 32'hA5A5_5A5A, 1'b1};
      tbl[4] = '{1'b1, 32'h0000_0020, 32'h0102_0304, 4'h9, 2, 32'hFFFF_FFFF, 1'b0, 2, 32'h0,         1'b0};
      tbl[5] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1, 32'h0000_0001, 1'b0, 0, 32'h0000_0001, 1'b0};

      #12;
      chk("reset_outs", {cmd_ready, PSELx, PENABLE, rsp_valid, rsp_err, rsp_timeout}, 6'b0);
      chk("reset_paddr", PADDR, 0);
      PRESETn = 1'b1;
      tick;
      chk("post_reset", {cmd_ready, PSELx, PENABLE, rsp_valid}, 4'b1000);

      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // asynchronous reset while a write sits in ACCESS
      wait_ready;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0040;
      cmd_wdata = 32'h7777_7777;
      cmd_strb  = 4'hF;
      tick;
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      tick;
      chk("rst_mid_access", {PSELx, PENABLE}, 2'b11);
      #2 PRESETn = 1'b0;
      #1 chk("rst_async", {PSELx, PENABLE, cmd_ready, rsp_valid}, 4'b0);
      tick;
      tick;
      PRESETn = 1'b1;
      PREADY  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("rst_no_rsp", {rsp_valid, PSELx}, 2'b0);
      end
      chk("rst_ready", cmd_ready, 1);
      PREADY = 1'b0;
      run_vec(tbl[1], "post_rst");

`ifdef APB_CMD_MASTER_TIMEOUT_EN
      wait_ready;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0080;
      sb.push_back('{32'h0, 1'b1, 1'b1});
      tick;
      cmd_valid = 1'b0;
      tick;
      for (int i = 0; i < 15; i++) tick;
      chk("tmo_still_access", {PSELx, PENABLE, rsp_valid}, 3'b110);
      tick;
      chk("tmo_abort", {PSELx, PENABLE, rsp_valid, rsp_err, rsp_timeout}, 5'b00111);
      take_rsp("tmo");
      wait_ready;
      cmd_valid = 1'b1;
      sb.push_back('{32'h0000_A5A5, 1'b0, 1'b0});
      tick;
      cmd_valid = 1'b0;
      tick;
      for (int i = 0; i < 15; i++) tick;
      PREADY = 1'b1;
      PRDATA = 32'h0000_A5A5;
      tick;
      PREADY = 1'b0;
      chk("tmo_edge_ok", {PSELx, rsp_valid, rsp_timeout}, 3'b010);
      take_rsp("tmo_edge");
`else
      wait_ready;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0080;
      tick;
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      for (int i = 0; i < 100; i++) tick;
      chk("no_tmo_wait", {PSELx, PENABLE, rsp_valid}, 3'b110);
      PREADY = 1'b1;
      PRDATA = 32'h0000_0055;
      sb.push_back('{32'h0000_0055, 1'b0, 1'b0});
      tick;
      PREADY = 1'b0;
      take_rsp("no_tmo");
`endif
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
